bitmap_encoder: RTL and testbench
=================================

Name: bitmap_encoder

Overview:
Encoder counterpart to the team's decode/fanout logic. It accepts a FANOUT-wide bitmap of asserted lines and serialises it into a stream of IO_SIZE-bit indices, one per set bit, using a valid/ready handshake. This recovers the binary indices that drove the decoded one-hot lines. It sits between the wide registered decode outputs and any narrow consumer (index bus, logger, arbiter).

Parameters:
FANOUT, 64, width of input bitmap; integer >= 2
IO_SIZE, $clog2(FANOUT), width of emitted index

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
inBus  input  FANOUT  bitmap to encode
inValid  input  1  inBus valid
inReady  output  1  block can accept a bitmap
outIdx  output  IO_SIZE  index of current set bit
outValid  output  1  outIdx valid
outReady  input  1  consumer accepts outIdx
outLast  output  1  current index is the final one of this bitmap
zeroErr  output  1  one-cycle pulse: an all-zero bitmap was accepted

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). All outputs are registered, except inReady, which is decoded from state.
- Reset (async, immediate): state=IDLE, pending=0, outIdx=0, outValid=0, outLast=0, zeroErr=0. inReady=1 on reset release.
- States: IDLE, DRAIN.
- inReady = (state==IDLE). No new bitmap is taken while draining.
- IDLE, on inValid && inReady:
  - inBus!=0: pending<=inBus; outIdx<=lowest set index of inBus; outValid<=1; outLast<=(inBus has exactly one bit set); go DRAIN.
  - inBus==0: zeroErr<=1 for exactly one cycle; remain IDLE; no outValid.
- zeroErr is cleared on every cycle that does not accept a zero bitmap.
- DRAIN, on outValid && outReady:
  - next = pending with bit outIdx cleared; pending<=next.
  - next==0: outValid<=0, outLast<=0, go IDLE. outIdx holds its last value.
  - next!=0: outIdx<=lowest set index of next; outLast<=(next has exactly one bit set).
- DRAIN with outReady=0: outIdx, outValid, outLast and pending all hold stable. The AXI-style rule applies: no retraction of outValid and no change of outIdx while stalled.
- Timing:
  - Latency: bitmap accepted at edge N; first index valid after edge N.
  - Throughput: one index per cycle with outReady=1.
  - A bitmap of k set bits occupies DRAIN for k handshake cycles, plus one IDLE cycle before the next accept.
- Width rules:
  - Index arithmetic is IO_SIZE bits, unsigned.
  - If FANOUT is not a power of 2, indices >= FANOUT are never produced.
  - The highest index is FANOUT-1 (e.g. 63 = 6'b111111). It must not wrap or truncate.
- inBus is sampled only on accept. Changes to inBus during DRAIN are ignored.
- Reset mid-DRAIN: the pending bitmap is discarded and outputs clear asynchronously. No partial stream resumes after reset release.
- inValid held high in IDLE with a non-zero bitmap: accepted on the first edge only. The next accept happens after return to IDLE.

Optional Feature:
Macro ENC_MSB_FIRST_EN.
- Defined: indices are emitted highest-first. The selection uses the highest set index of pending; outLast marks the lowest set bit.
- Undefined (default): indices are emitted lowest-first as above.
- All other timing and handshake behaviour is identical in both builds.

Test Plan:
1. Reset: assert reset mid-cycle, async check -> outValid=0, outLast=0, zeroErr=0, outIdx=0; after release inReady=1.
2. FANOUT=64, inBus=64'h8000_0000_0000_0005, outReady=1 -> outIdx=0,2,63 on three consecutive cycles; outLast=1 only with 63; inReady=0 during DRAIN, 1 the cycle after.
3. Backpressure: inBus=bits 5 and 9, outReady=0 for 4 cycles -> outIdx=5 and outValid=1 stable for 4 cycles; then outReady=1 gives 5, then 9 with outLast=1.
4. inBus=0 with inValid=1 -> zeroErr=1 for exactly one cycle; outValid stays 0; state remains IDLE (inReady=1).
5. Reset during DRAIN after index 0 of 64'h...0005 is taken -> outValid drops immediately. A new inBus=64'h10 then yields a single outIdx=4 with outLast=1.
6. With ENC_MSB_FIRST_EN defined, inBus=64'h8000_0000_0000_0005 -> outIdx=63,2,0; outLast=1 with 0.

Source files
------------

// File: rtl/bitmap_encoder.sv
// rtl/bitmap_encoder.sv - serialises a FANOUT-wide bitmap into a stream of set-bit indices (option: ENC_MSB_FIRST_EN)
module bitmap_encoder #(
    parameter int FANOUT  = 64,
    parameter int IO_SIZE = $clog2(FANOUT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FANOUT-1:0]  inBus,
    input  logic               inValid,
    output logic               inReady,
    output logic [IO_SIZE-1:0] outIdx,
    output logic               outValid,
    input  logic               outReady,
    output logic               outLast,
    output logic               zeroErr
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [FANOUT-1:0]    r_pending;
    logic [FANOUT-1:0]    w_pending_nxt;
    logic [IO_SIZE-1:0]   r_idx;
    logic [IO_SIZE-1:0]   w_idx_nxt;
    logic                 r_valid;
    logic                 w_valid_nxt;
    logic                 r_last;
    logic                 w_last_nxt;
    logic                 r_zero_err;
    logic                 w_zero_err_nxt;

    logic [FANOUT-1:0]    w_remain;
    logic [IO_SIZE-1:0]   w_sel_in;
    logic [IO_SIZE-1:0]   w_sel_remain;
    logic                 w_single_in;
    logic                 w_single_remain;

    // Picks the index emitted first from a bitmap; only set bits are ever
    // chosen, so indices >= FANOUT cannot appear for non-power-of-2 widths.
    function automatic logic [IO_SIZE-1:0] f_select(input logic [FANOUT-1:0] v);
        logic [IO_SIZE-1:0] idx;
        idx = '0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < FANOUT; i++) begin
            if (v[i]) idx = IO_SIZE'(i);
        end
`else
        for (int i = FANOUT - 1; i >= 0; i--) begin
            if (v[i]) idx = IO_SIZE'(i);
        end
`endif
        return idx;
    endfunction

    // True when exactly one bit is set: the selected index is then the last.
    function automatic logic f_single(input logic [FANOUT-1:0] v);
        return (v != '0) && ((v & (v - FANOUT'(1))) == '0);
    endfunction

    assign w_remain        = r_pending & ~(FANOUT'(1) << r_idx);
    assign w_sel_in        = f_select(inBus);
    assign w_sel_remain    = f_select(w_remain);
    assign w_single_in     = f_single(inBus);
    assign w_single_remain = f_single(w_remain);

    assign inReady  = (r_state == S_IDLE);
    assign outIdx   = r_idx;
    assign outValid = r_valid;
    assign outLast  = r_last;
    assign zeroErr  = r_zero_err;

    // Next-state and next-output decode; everything holds unless a handshake occurs.
    always_comb begin
        w_state_nxt    = r_state;
        w_pending_nxt  = r_pending;
        w_idx_nxt      = r_idx;
        w_valid_nxt    = r_valid;
        w_last_nxt     = r_last;
        w_zero_err_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (inValid) begin
                    if (inBus != '0) begin
                        w_pending_nxt = inBus;
                        w_idx_nxt     = w_sel_in;
                        w_valid_nxt   = 1'b1;
                        w_last_nxt    = w_single_in;
                        w_state_nxt   = S_DRAIN;
                    end else begin
                        w_zero_err_nxt = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (r_valid && outReady) begin
                    w_pending_nxt = w_remain;
                    if (w_remain == '0) begin
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt  = w_sel_remain;
                        w_last_nxt = w_single_remain;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and registered outputs; reset discards any partially drained bitmap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pending  <= '0;
            r_idx      <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_zero_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= w_pending_nxt;
            r_idx      <= w_idx_nxt;
            r_valid    <= w_valid_nxt;
            r_last     <= w_last_nxt;
            r_zero_err <= w_zero_err_nxt;
        end
    end

endmodule

// File: tb/tb_bitmap_encoder.sv
// tb/tb_bitmap_encoder.sv - self-checking bench for bitmap_encoder against a queue model
module tb_bitmap_encoder;
    localparam int FANOUT  = 64;
    localparam int IO_SIZE = 6;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [FANOUT-1:0]  inBus = '0;
    logic               inValid = 1'b0;
    logic               inReady;
    logic [IO_SIZE-1:0] outIdx;
    logic               outValid;
    logic               outReady = 1'b0;
    logic               outLast;
    logic               zeroErr;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    bitmap_encoder #(.FANOUT(FANOUT), .IO_SIZE(IO_SIZE)) dut (
        .clk(clk), .reset(reset), .inBus(inBus), .inValid(inValid), .inReady(inReady),
        .outIdx(outIdx), .outValid(outValid), .outReady(outReady), .outLast(outLast),
        .zeroErr(zeroErr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Expected emission order: every set bit, in the configured direction.
    task automatic build_expected(input logic [FANOUT-1:0] bm);
        exp_q.delete();
        for (int i = 0; i < FANOUT; i++) begin
            if (bm[i]) begin
`ifdef ENC_MSB_FIRST_EN
                exp_q.push_front(i);
`else
                exp_q.push_back(i);
`endif
            end
        end
    endtask

    task automatic send_bitmap(input logic [FANOUT-1:0] bm, input bit hold);
        @(negedge clk);
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: inReady=%b expected 1", inReady);
        end
        inBus   = bm;
        inValid = 1'b1;
        build_expected(bm);
        if (!hold) begin
            @(posedge clk);
            #1;
            inValid = 1'b0;
            inBus   = {$urandom, $urandom};
        end
    endtask

    task automatic drain_check(input string name, input int stall_first, input bit rand_ready);
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            if (cyc > 2000) begin
                errors++;
                checks++;
                $display("FAIL %s timeout: %0d indices still pending", name, exp_q.size());
                exp_q.delete();
                break;
            end
            checks++;
            if (outValid !== 1'b1) begin
                errors++;
                $display("FAIL %s outValid: got %b expected 1 (cycle %0d)", name, outValid, cyc);
            end
            checks++;
            if (inReady !== 1'b0) begin
                errors++;
                $display("FAIL %s inReady_drain: got %b expected 0", name, inReady);
            end
            checks++;
            if (outIdx !== IO_SIZE'(exp_q[0])) begin
                errors++;
                $display("FAIL %s outIdx: got %0d expected %0d", name, outIdx, exp_q[0]);
            end
            checks++;
            if (outLast !== 1'(exp_q.size() == 1)) begin
                errors++;
                $display("FAIL %s outLast: got %b expected %b", name, outLast, exp_q.size() == 1);
            end
            if (cyc < stall_first) outReady = 1'b0;
            else if (rand_ready)   outReady = 1'($urandom_range(0, 1));
            else                   outReady = 1'b1;
            cyc++;
            if (outReady) void'(exp_q.pop_front());
        end
        @(negedge clk);
        checks++;
        if (outValid !== 1'b0 || outLast !== 1'b0 || inReady !== 1'b1) begin
            errors++;
            $display("FAIL %s end_idle: outValid=%b outLast=%b inReady=%b expected 0 0 1",
                     name, outValid, outLast, inReady);
        end
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        #2;
        checks++;
        if (outValid !== 1'b0 || outLast !== 1'b0 || zeroErr !== 1'b0 || outIdx !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b last=%b zero=%b idx=%0d expected all 0",
                     outValid, outLast, zeroErr, outIdx);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_inready: got %b expected 1", inReady);
        end
    endtask

    task automatic test_directed;
        send_bitmap(64'h8000_0000_0000_0005, 1'b0);
        drain_check("directed_0_2_63", 0, 1'b0);
    endtask

    task automatic test_backpressure;
        send_bitmap(64'h0000_0000_0000_0220, 1'b0);
        drain_check("backpressure", 4, 1'b0);
    endtask

    task automatic test_zero;
        @(negedge clk);
        inBus   = '0;
        inValid = 1'b1;
        @(posedge clk);
        #1 inValid = 1'b0;
        @(negedge clk);
        checks++;
        if (zeroErr !== 1'b1 || outValid !== 1'b0 || inReady !== 1'b1) begin
            errors++;
            $display("FAIL zero_pulse: zeroErr=%b outValid=%b inReady=%b expected 1 0 1",
                     zeroErr, outValid, inReady);
        end
        @(negedge clk);
        checks++;
        if (zeroErr !== 1'b0 || outValid !== 1'b0) begin
            errors++;
            $display("FAIL zero_clear: zeroErr=%b outValid=%b expected 0 0", zeroErr, outValid);
        end
    endtask

    task automatic test_reset_mid_drain;
        send_bitmap(64'h8000_0000_0000_0005, 1'b0);
        @(negedge clk);
        outReady = 1'b1;
        @(negedge clk);
        checks++;
        if (outValid !== 1'b1 || outIdx !== IO_SIZE'(exp_q[1])) begin
            errors++;
            $display("FAIL mid_progress: valid=%b idx=%0d expected 1 %0d", outValid, outIdx, exp_q[1]);
        end
        outReady = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (outValid !== 1'b0 || outIdx !== '0 || outLast !== 1'b0 || inReady !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_async: valid=%b idx=%0d last=%b ready=%b expected 0 0 0 1",
                     outValid, outIdx, outLast, inReady);
        end
        exp_q.delete();
        @(negedge clk);
        reset    = 1'b0;
        outReady = 1'b1;
        @(negedge clk);
        checks++;
        if (outValid !== 1'b0 || inReady !== 1'b1) begin
            errors++;
            $display("FAIL mid_no_resume: valid=%b ready=%b expected 0 1", outValid, inReady);
        end
        send_bitmap(64'h10, 1'b0);
        drain_check("after_reset_4", 0, 1'b0);
    endtask

    task automatic test_back_to_back;
        send_bitmap(64'h8000_0000_0000_0101, 1'b1);
        drain_check("hold_first", 0, 1'b1);
        build_expected(inBus);
        drain_check("hold_second", 0, 1'b0);
        inValid = 1'b0;
        @(negedge clk);
        checks++;
        if (outValid !== 1'b0 || inReady !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: valid=%b ready=%b expected 0 1", outValid, inReady);
        end
    endtask

    task automatic test_random;
        logic [FANOUT-1:0] bm;
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0: bm = FANOUT'(1) << $urandom_range(0, FANOUT - 1);
                1: bm = {$urandom, $urandom};
                2: bm = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                default: bm = 64'h8000_0000_0000_0001 | (FANOUT'(1) << $urandom_range(0, FANOUT - 1));
            endcase
            if (bm == '0) bm = 64'h8000_0000_0000_0000;
            send_bitmap(bm, 1'b0);
            drain_check("random", 0, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_zero();
        test_reset_mid_drain();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
